// File: rtl/sebc_bus_pkg.sv
// Shared definitions for the Gray-coded address bus codec blocks.
`timescale 1ns/1ps
package sebc_bus_pkg;

  localparam int unsigned BUS_W = 8;
  localparam int unsigned POP_W = $clog2(BUS_W + 1);

  typedef enum logic {
    EMPTY  = 1'b0,
    PRIMED = 1'b1
  } gray_state_e;

  // Gray to binary: each binary bit is the xor of all Gray bits at or above it.
  function automatic logic [BUS_W-1:0] gray2bin(input logic [BUS_W-1:0] g);
    logic [BUS_W-1:0] b;
    b[BUS_W-1] = g[BUS_W-1];
    for (int i = int'(BUS_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [BUS_W-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(BUS_W); i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/gray_bus_decoder_if.sv
// Gray bus link between the encoder side (master) and the decoder (slave).
`timescale 1ns/1ps
interface gray_bus_decoder_if
  import sebc_bus_pkg::*;
#(
  parameter int unsigned WIDTH = BUS_W
);
  logic [WIDTH-1:0] gray_in;
  logic             in_valid;
  logic [WIDTH-1:0] addr_out;
  logic             out_valid;
  logic             seq_flag;

  modport master (
    output gray_in, in_valid,
    input  addr_out, out_valid, seq_flag
  );

  modport slave (
    input  gray_in, in_valid,
    output addr_out, out_valid, seq_flag
  );
endinterface

// File: rtl/sat_counter.sv
// Accumulator that clamps at its maximum and raises a sticky saturation flag.
`timescale 1ns/1ps
module sat_counter #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned INC_W = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SUM_W-1:0] sum_c;
  logic [CNT_W-1:0] nxt_c;

  always_comb begin
    sum_c = SUM_W'(cnt) + SUM_W'(inc);
    nxt_c = CNT_W'(sum_c);
    if (sum_c > SUM_W'(CNT_MAX)) nxt_c = CNT_MAX;
  end

  // Clear wins over any increment arriving in the same cycle.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= nxt_c;
      if (nxt_c == CNT_MAX) sat <= 1'b1;
    end
  end
endmodule

// File: rtl/gray_bus_decoder.sv
// Gray bus receiver: two-stage decode pipeline plus transition/sequential statistics.
`timescale 1ns/1ps
module gray_bus_decoder
  import sebc_bus_pkg::*;
#(
  parameter int unsigned WIDTH = BUS_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             ck,
  input  logic             rst,
  gray_bus_decoder_if.slave bus,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] trans_cnt,
  output logic [CNT_W-1:0] seq_cnt,
  output logic             cnt_sat
);
  logic [WIDTH-1:0] g_q;
  logic             v1_q;
  logic [WIDTH-1:0] last_gray_q;
  logic [WIDTH-1:0] addr_q;
  logic             ov_q;
  logic             seq_q;
  logic             out_primed_q;
  gray_state_e      in_state_q, in_state_d;
  logic             count_en_c;
  logic [WIDTH-1:0] bin_c;
  logic             seq_match_c;
  logic [POP_W-1:0] trans_inc_c;
  logic             sat_t, sat_s;

  // Input stage: capture on valid, hold otherwise.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      g_q         <= '0;
      v1_q        <= 1'b0;
      last_gray_q <= '0;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        g_q         <= bus.gray_in;
        last_gray_q <= bus.gray_in;
      end
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) in_state_q <= EMPTY;
    else     in_state_q <= in_state_d;
  end

  // A word arriving with a clear is the new history word, so it re-primes.
  always_comb begin
    in_state_d = in_state_q;
    case (in_state_q)
      EMPTY:   if (bus.in_valid) in_state_d = PRIMED;
      PRIMED:  if (!bus.in_valid && clr_stats) in_state_d = EMPTY;
      default: in_state_d = EMPTY;
    endcase
  end

  always_comb begin
    count_en_c = 1'b0;
    if (in_state_q == PRIMED && bus.in_valid && !clr_stats) count_en_c = 1'b1;
  end

  always_comb begin
    bin_c       = WIDTH'(gray2bin(BUS_W'(g_q)));
    seq_match_c = (bin_c == addr_q + WIDTH'(1));
    trans_inc_c = count_en_c ? popcount(BUS_W'(bus.gray_in ^ last_gray_q)) : '0;
  end

  // Output stage; seq_flag is computed against the address it replaces.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      ov_q         <= 1'b0;
      seq_q        <= 1'b0;
      out_primed_q <= 1'b0;
    end else begin
      ov_q  <= v1_q;
      seq_q <= v1_q && out_primed_q && seq_match_c;
      if (v1_q) begin
        addr_q       <= bin_c;
        out_primed_q <= 1'b1;
      end else if (clr_stats) begin
        out_primed_q <= 1'b0;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W), .INC_W(POP_W)) u_trans_cnt (
    .ck  (ck),
    .rst (rst),
    .clr (clr_stats),
    .inc (trans_inc_c),
    .cnt (trans_cnt),
    .sat (sat_t)
  );

  sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_seq_cnt (
    .ck  (ck),
    .rst (rst),
    .clr (clr_stats),
    .inc (seq_q),
    .cnt (seq_cnt),
    .sat (sat_s)
  );

  assign bus.addr_out  = addr_q;
  assign bus.out_valid = ov_q;
  assign bus.seq_flag  = seq_q;
  assign cnt_sat       = sat_t | sat_s;
endmodule

// File: tb/tb_gray_bus_decoder.sv
// Bench for gray_bus_decoder: directed vectors, saturation/clear/reset sequences, random model run.
`timescale 1ns/1ps
module tb_gray_bus_decoder;
  import sebc_bus_pkg::*;

  localparam int unsigned W   = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned CW4 = 4;

  logic ck  = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] gray;
  logic vld;
  logic clr;

  logic [CW-1:0]  trans16, seqc16;
  logic           sat16;
  logic [CW4-1:0] trans4, seqc4;
  logic           sat4;

  gray_bus_decoder_if #(.WIDTH(W)) bus16 ();
  gray_bus_decoder_if #(.WIDTH(W)) bus4 ();

  assign bus16.gray_in  = gray;
  assign bus16.in_valid = vld;
  assign bus4.gray_in   = gray;
  assign bus4.in_valid  = vld;

  gray_bus_decoder #(.WIDTH(W), .CNT_W(CW)) dut (
    .ck(ck), .rst(rst), .bus(bus16), .clr_stats(clr),
    .trans_cnt(trans16), .seq_cnt(seqc16), .cnt_sat(sat16)
  );

  gray_bus_decoder #(.WIDTH(W), .CNT_W(CW4)) dut4 (
    .ck(ck), .rst(rst), .bus(bus4), .clr_stats(clr),
    .trans_cnt(trans4), .seq_cnt(seqc4), .cnt_sat(sat4)
  );

  always #5 ck = ~ck;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [7:0] addr, input logic ov,
                       input logic seq, input logic [15:0] trans, input logic [15:0] seqc);
    chk({tag, ".addr"},  32'(bus16.addr_out),  32'(addr));
    chk({tag, ".ov"},    32'(bus16.out_valid), 32'(ov));
    chk({tag, ".seq"},   32'(bus16.seq_flag),  32'(seq));
    chk({tag, ".trans"}, 32'(trans16),         32'(trans));
    chk({tag, ".seqc"},  32'(seqc16),          32'(seqc));
  endtask

  task automatic step(input logic [7:0] g, input logic v, input logic c);
    gray = g;
    vld  = v;
    clr  = c;
    @(posedge ck);
    #1;
  endtask

  typedef struct {
    logic [7:0]  g;
    logic        v;
    logic [7:0]  addr;
    logic        ov;
    logic        seq;
    logic [15:0] trans;
    logic [15:0] seqc;
  } vec_t;

  vec_t vecs[9];

  // Reference model state for the random run.
  logic [7:0]  m_g1, m_last, m_addr, mb;
  logic        m_v1, m_iprim, m_oprim, m_ov, m_seq;
  logic [15:0] m_trans, m_seqc;

  initial begin
    // Ramp 00,01,03,02 then wrap FF -> 00, outputs two edges behind.
    vecs[0] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[1] = '{8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 16'd1, 16'd0};
    vecs[2] = '{8'h03, 1'b1, 8'h01, 1'b1, 1'b1, 16'd2, 16'd0};
    vecs[3] = '{8'h02, 1'b1, 8'h02, 1'b1, 1'b1, 16'd3, 16'd1};
    vecs[4] = '{8'h80, 1'b1, 8'h03, 1'b1, 1'b1, 16'd5, 16'd2};
    vecs[5] = '{8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 16'd6, 16'd3};
    vecs[6] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 16'd6, 16'd3};
    vecs[7] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'd6, 16'd4};
    vecs[8] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'd6, 16'd4};

    gray = '0;
    vld  = 1'b0;
    clr  = 1'b0;

    // Reset
    #0.1 rst = 1'b1;
    #2;
    chk16("rst_hold", 8'h00, 1'b0, 1'b0, 16'd0, 16'd0);
    chk("rst_hold.sat", 32'(sat16), 32'd0);
    #10 rst = 1'b0;
    @(posedge ck);
    #1;
    chk16("rst_edge", 8'h00, 1'b0, 1'b0, 16'd0, 16'd0);
    chk("rst_edge.sat", 32'(sat16), 32'd0);

    // Directed ramp and wrap
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].g, vecs[i].v, 1'b0);
      chk16($sformatf("vec%0d", i), vecs[i].addr, vecs[i].ov, vecs[i].seq,
            vecs[i].trans, vecs[i].seqc);
    end

    // Async reset with a word sitting in S1
    step(8'h01, 1'b1, 1'b0);
    chk("pre_rst.trans", 32'(trans16), 32'd7);
    vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk16("async_rst", 8'h00, 1'b0, 1'b0, 16'd0, 16'd0);
    @(posedge ck);
    #1 rst = 1'b0;
    step(8'h00, 1'b0, 1'b0);
    chk("drop0.ov", 32'(bus16.out_valid), 32'd0);
    step(8'h00, 1'b0, 1'b0);
    chk("drop1.ov", 32'(bus16.out_valid), 32'd0);
    step(8'h0F, 1'b1, 1'b0);
    chk("post_rst_first.trans", 32'(trans16), 32'd0);
    step(8'h0E, 1'b1, 1'b0);
    chk16("post_rst_second", 8'h0A, 1'b1, 1'b0, 16'd1, 16'd0);
    step(8'h00, 1'b0, 1'b0);
    chk16("post_rst_seq", 8'h0B, 1'b1, 1'b1, 16'd1, 16'd0);

    // Saturation and clear on the 4-bit counter instance
    step(8'h00, 1'b0, 1'b1);
    chk("sat_clr0.trans4", 32'(trans4), 32'd0);
    chk("sat_clr0.seqc4", 32'(seqc4), 32'd0);
    step(8'h00, 1'b1, 1'b0);
    chk("sat_a.trans4", 32'(trans4), 32'd0);
    step(8'hFF, 1'b1, 1'b0);
    chk("sat_b.trans4", 32'(trans4), 32'd8);
    chk("sat_b.sat4", 32'(sat4), 32'd0);
    step(8'h00, 1'b1, 1'b0);
    chk("sat_c.trans4", 32'(trans4), 32'd15);
    chk("sat_c.sat4", 32'(sat4), 32'd1);
    step(8'h00, 1'b0, 1'b0);
    chk("sat_hold.trans4", 32'(trans4), 32'd15);
    chk("sat_hold.sat4", 32'(sat4), 32'd1);
    step(8'hFF, 1'b1, 1'b0);
    chk("sat_more.trans4", 32'(trans4), 32'd15);
    chk("sat_more.sat4", 32'(sat4), 32'd1);
    step(8'h0F, 1'b1, 1'b1);
    chk("clr_word.trans4", 32'(trans4), 32'd0);
    chk("clr_word.sat4", 32'(sat4), 32'd0);
    chk("clr_word.seqc4", 32'(seqc4), 32'd0);
    step(8'h0E, 1'b1, 1'b0);
    chk("after_clr.trans4", 32'(trans4), 32'd1);
    chk("after_clr.sat4", 32'(sat4), 32'd0);

    // Random stream against a reference model
    rst = 1'b1;
    vld = 1'b0;
    clr = 1'b0;
    #2 rst = 1'b0;
    m_g1 = '0; m_last = '0; m_addr = '0; m_v1 = 1'b0; m_iprim = 1'b0;
    m_oprim = 1'b0; m_ov = 1'b0; m_seq = 1'b0; m_trans = '0; m_seqc = '0;
    for (int n = 0; n < 400; n++) begin
      logic [7:0]  g;
      logic        v, c;
      logic [31:0] tsum;
      g = 8'($urandom);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      mb = m_g1;
      for (int s = 1; s < 8; s++) mb = mb ^ (m_g1 >> s);
      tsum = 32'(m_trans) + 32'($countones(g ^ m_last));
      if (tsum > 32'hFFFF) tsum = 32'hFFFF;
      if (c)                  m_trans = '0;
      else if (v && m_iprim)  m_trans = 16'(tsum);
      if (c)                  m_seqc = '0;
      else if (m_seq && m_seqc != 16'hFFFF) m_seqc = m_seqc + 16'd1;
      m_seq = m_v1 && m_oprim && (mb == 8'(m_addr + 8'd1));
      m_ov  = m_v1;
      if (m_v1) begin
        m_addr  = mb;
        m_oprim = 1'b1;
      end else if (c) begin
        m_oprim = 1'b0;
      end
      if (v)      m_iprim = 1'b1;
      else if (c) m_iprim = 1'b0;
      if (v) begin
        m_last = g;
        m_g1   = g;
      end
      m_v1 = v;
      step(g, v, c);
      chk16($sformatf("rnd%0d", n), m_addr, m_ov, m_seq, m_trans, m_seqc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
